// File: rtl/pu_or1k_branch_resolver_pkg.sv
// Shared types and constants for the execute-stage conditional branch resolver.
package pu_or1k_branch_pkg;

    // Lifecycle of the single conditional branch tracked in execute.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_FLAG = 2'd1,
        RESOLVED  = 2'd2
    } branch_state_t;

    // The delay slot always executes, so a not-taken branch resumes two words on.
    localparam int FALL_OFFSET = 8;

    // Width of the performance statistics counters.
    localparam int COUNT_WIDTH = 32;

endpackage

// File: rtl/pu_or1k_branch_resolver_if.sv
// Decode/execute-side signals of the branch resolver, plus its redirect and statistics outputs.
interface pu_or1k_branch_resolver_if
    import pu_or1k_branch_pkg::*;
#(
    parameter int W = 32
);
    logic                   padv_decode_i;
    logic [W-1:0]           pc_decode_i;
    logic                   op_bf_i;
    logic                   op_bnf_i;
    logic [25:0]            immjbr_i;
    logic                   predicted_flag_i;
    logic                   flag_valid_i;
    logic                   flag_i;
    logic                   padv_execute_i;
    logic                   pipeline_flush_i;
    logic                   branch_mispredict_o;
    logic [W-1:0]           mispredict_target_o;
    logic                   execute_stall_o;
    logic [COUNT_WIDTH-1:0] branch_count_o;
    logic [COUNT_WIDTH-1:0] mispredict_count_o;

    // Pipeline side: drives decode/execute information, observes redirects.
    modport master (
        output padv_decode_i, pc_decode_i, op_bf_i, op_bnf_i, immjbr_i,
               predicted_flag_i, flag_valid_i, flag_i, padv_execute_i,
               pipeline_flush_i,
        input  branch_mispredict_o, mispredict_target_o, execute_stall_o,
               branch_count_o, mispredict_count_o
    );

    // Resolver side.
    modport slave (
        input  padv_decode_i, pc_decode_i, op_bf_i, op_bnf_i, immjbr_i,
               predicted_flag_i, flag_valid_i, flag_i, padv_execute_i,
               pipeline_flush_i,
        output branch_mispredict_o, mispredict_target_o, execute_stall_o,
               branch_count_o, mispredict_count_o
    );

endinterface

// File: rtl/pu_or1k_branch_resolver_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones instead of wrapping.
module pu_or1k_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment only while below the ceiling.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pu_or1k_branch_resolver.sv
// Resolves l.bf/l.bnf against the real SR[F] in execute and issues a one-cycle
// fetch redirect when the static prediction was wrong; keeps branch statistics.
module pu_or1k_branch_resolver
    import pu_or1k_branch_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter     FEATURE_PERF_COUNTERS = "ENABLED"
) (
    input logic                      clk,
    input logic                      rst,
    pu_or1k_branch_resolver_if.slave bus
);

    localparam int W = OPTION_OPERAND_WIDTH;

    branch_state_t state_q, state_d;

    logic [W-1:0] target_q, target_d;
    logic [W-1:0] fall_q, fall_d;
    logic [W-1:0] redirect_pc_q, redirect_pc_d;
    logic         is_bf_q, is_bf_d;
    logic         pred_q, pred_d;
    logic         pulse_q, pulse_d;

    logic         is_branch;
    logic         capture;
    logic         resolve;
    logic         taken;
    logic         mispredict;
    logic [W-1:0] branch_offset;

    assign is_branch     = bus.op_bf_i | bus.op_bnf_i;
    // Word offset, sign-extended and scaled to bytes.
    assign branch_offset = {{(W-28){bus.immjbr_i[25]}}, bus.immjbr_i, 2'b00};
    assign taken         = is_bf_q ? bus.flag_i : ~bus.flag_i;
    assign mispredict    = (taken != pred_q);

    // Next-state, capture/resolve strobes and redirect data.
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        resolve       = 1'b0;
        target_d      = target_q;
        fall_d        = fall_q;
        is_bf_d       = is_bf_q;
        pred_d        = pred_q;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            EMPTY: begin
                capture = bus.padv_decode_i & is_branch;
            end
            WAIT_FLAG: begin
                resolve = bus.flag_valid_i;
            end
            RESOLVED: begin
                if (bus.padv_execute_i) begin
                    state_d = EMPTY;
                    capture = bus.padv_decode_i & is_branch;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A flush discards everything, including a capture or resolution this cycle.
        if (bus.pipeline_flush_i) begin
            capture = 1'b0;
            resolve = 1'b0;
        end

        if (capture) begin
            state_d  = WAIT_FLAG;
            target_d = bus.pc_decode_i + branch_offset;
            fall_d   = bus.pc_decode_i + W'(FALL_OFFSET);
            is_bf_d  = bus.op_bf_i;
            pred_d   = bus.predicted_flag_i;
        end else if (resolve) begin
            state_d = RESOLVED;
        end else if (bus.pipeline_flush_i) begin
            state_d = EMPTY;
        end

        pulse_d = resolve & mispredict;
        if (pulse_d) begin
            redirect_pc_d = taken ? target_q : fall_q;
        end
    end

    // State, captured branch and registered redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            target_q      <= '0;
            fall_q        <= '0;
            is_bf_q       <= 1'b0;
            pred_q        <= 1'b0;
            pulse_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            fall_q        <= fall_d;
            is_bf_q       <= is_bf_d;
            pred_q        <= pred_d;
            pulse_q       <= pulse_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.branch_mispredict_o = pulse_q;
    assign bus.mispredict_target_o = redirect_pc_q;
    assign bus.execute_stall_o     = (state_q == WAIT_FLAG);

    logic [COUNT_WIDTH-1:0] branch_count;
    logic [COUNT_WIDTH-1:0] mispredict_count;

    if (FEATURE_PERF_COUNTERS == "NONE") begin : g_no_perf
        assign branch_count     = '0;
        assign mispredict_count = '0;
    end else begin : g_perf
        pu_or1k_sat_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_branch_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (resolve),
            .count_o (branch_count)
        );

        pu_or1k_sat_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_mispredict_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (resolve & mispredict),
            .count_o (mispredict_count)
        );
    end

    assign bus.branch_count_o     = branch_count;
    assign bus.mispredict_count_o = mispredict_count;

endmodule

// File: tb/tb_pu_or1k_branch_resolver.sv
// Directed self-checking bench for pu_or1k_branch_resolver.
module tb_pu_or1k_branch_resolver;
    import pu_or1k_branch_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_br;
    logic [31:0] exp_mp;

    always #5 clk = ~clk;

    pu_or1k_branch_resolver_if #(.W(32)) bus ();

    pu_or1k_branch_resolver #(
        .OPTION_OPERAND_WIDTH  (32),
        .FEATURE_PERF_COUNTERS ("ENABLED")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Protocol watch: execute must never advance while a branch is unresolved.
    always @(posedge clk) begin
        if (!rst && bus.execute_stall_o && bus.padv_execute_i) begin
            failures++;
            $display("FAIL protocol: padv_execute_i=1 while execute_stall_o=1");
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.padv_decode_i    = 1'b0;
        bus.pc_decode_i      = '0;
        bus.op_bf_i          = 1'b0;
        bus.op_bnf_i         = 1'b0;
        bus.immjbr_i         = '0;
        bus.predicted_flag_i = 1'b0;
        bus.flag_valid_i     = 1'b0;
        bus.flag_i           = 1'b0;
        bus.padv_execute_i   = 1'b0;
        bus.pipeline_flush_i = 1'b0;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic [25:0] imm,
                                input logic is_bf, input logic pred);
        bus.padv_decode_i    = 1'b1;
        bus.pc_decode_i      = pc;
        bus.immjbr_i         = imm;
        bus.op_bf_i          = is_bf;
        bus.op_bnf_i         = ~is_bf;
        bus.predicted_flag_i = pred;
    endtask

    task automatic clear_decode();
        bus.padv_decode_i = 1'b0;
        bus.op_bf_i       = 1'b0;
        bus.op_bnf_i      = 1'b0;
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (bus.branch_count_o !== exp_br) begin
            failures++;
            $display("FAIL %s branch_count: got %h expected %h", name, bus.branch_count_o, exp_br);
        end
        checks++;
        if (bus.mispredict_count_o !== exp_mp) begin
            failures++;
            $display("FAIL %s mispredict_count: got %h expected %h", name, bus.mispredict_count_o, exp_mp);
        end
    endtask

    task automatic retire();
        bus.padv_execute_i = 1'b1;
        tick();
        bus.padv_execute_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_br = 32'd0;
        exp_mp = 32'd0;
        checks++;
        if (bus.branch_mispredict_o !== 1'b0) begin
            failures++;
            $display("FAIL reset pulse: got %b expected 0", bus.branch_mispredict_o);
        end
        checks++;
        if (bus.mispredict_target_o !== 32'h0) begin
            failures++;
            $display("FAIL reset target: got %h expected 0", bus.mispredict_target_o);
        end
        checks++;
        if (bus.execute_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset stall: got %b expected 0", bus.execute_stall_o);
        end
        check_counts("reset");
    endtask

    task automatic test_predicted_correct();
        drive_branch(32'h100, 26'h3FFFFFC, 1'b1, 1'b1);
        tick();
        clear_decode();
        checks++;
        if (bus.execute_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL correct stall: got %b expected 1", bus.execute_stall_o);
        end
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b1;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        checks++;
        if (bus.branch_mispredict_o !== 1'b0) begin
            failures++;
            $display("FAIL correct pulse: got %b expected 0", bus.branch_mispredict_o);
        end
        checks++;
        if (bus.execute_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL correct stall_after: got %b expected 0", bus.execute_stall_o);
        end
        check_counts("correct");
        retire();
    endtask

    task automatic test_mispredict_bnf();
        drive_branch(32'h200, 26'h10, 1'b0, 1'b0);
        tick();
        clear_decode();
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b0;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        exp_mp = exp_mp + 1;
        checks++;
        if (bus.branch_mispredict_o !== 1'b1) begin
            failures++;
            $display("FAIL bnf pulse: got %b expected 1", bus.branch_mispredict_o);
        end
        checks++;
        if (bus.mispredict_target_o !== 32'h240) begin
            failures++;
            $display("FAIL bnf target: got %h expected 240", bus.mispredict_target_o);
        end
        check_counts("bnf");
        retire();
        checks++;
        if (bus.branch_mispredict_o !== 1'b0) begin
            failures++;
            $display("FAIL bnf pulse_width: got %b expected 0", bus.branch_mispredict_o);
        end
    endtask

    task automatic test_wrong_taken();
        drive_branch(32'h300, 26'h40, 1'b1, 1'b1);
        tick();
        clear_decode();
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b0;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        exp_mp = exp_mp + 1;
        checks++;
        if (bus.branch_mispredict_o !== 1'b1 || bus.mispredict_target_o !== 32'h308) begin
            failures++;
            $display("FAIL wrong_taken redirect: got pulse=%b target=%h expected pulse=1 target=308",
                     bus.branch_mispredict_o, bus.mispredict_target_o);
        end
        check_counts("wrong_taken");
        retire();
    endtask

    task automatic test_non_branch();
        bus.padv_decode_i = 1'b1;
        bus.pc_decode_i   = 32'h380;
        bus.flag_valid_i  = 1'b1;
        tick();
        tick();
        bus.padv_decode_i = 1'b0;
        bus.flag_valid_i  = 1'b0;
        checks++;
        if (bus.execute_stall_o !== 1'b0 || bus.branch_mispredict_o !== 1'b0) begin
            failures++;
            $display("FAIL non_branch: got stall=%b pulse=%b expected 0/0",
                     bus.execute_stall_o, bus.branch_mispredict_o);
        end
        check_counts("non_branch");
    endtask

    task automatic test_delayed_flag();
        drive_branch(32'h400, 26'h8, 1'b1, 1'b0);
        tick();
        clear_decode();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.execute_stall_o !== 1'b1) begin
                failures++;
                $display("FAIL delayed stall[%0d]: got %b expected 1", i, bus.execute_stall_o);
            end
            tick();
        end
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b0;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        checks++;
        if (bus.execute_stall_o !== 1'b0 || bus.branch_mispredict_o !== 1'b0) begin
            failures++;
            $display("FAIL delayed resolve: got stall=%b pulse=%b expected 0/0",
                     bus.execute_stall_o, bus.branch_mispredict_o);
        end
        check_counts("delayed");
        retire();
    endtask

    task automatic test_back_to_back();
        drive_branch(32'h500, 26'h4, 1'b1, 1'b1);
        tick();
        clear_decode();
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b1;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        // Retire the first branch while the next one leaves decode.
        bus.padv_execute_i = 1'b1;
        drive_branch(32'h600, 26'h3FFFFF0, 1'b0, 1'b0);
        tick();
        bus.padv_execute_i = 1'b0;
        clear_decode();
        checks++;
        if (bus.execute_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b capture: got stall=%b expected 1", bus.execute_stall_o);
        end
        bus.flag_valid_i = 1'b1;
        bus.flag_i       = 1'b0;
        tick();
        bus.flag_valid_i = 1'b0;
        exp_br = exp_br + 1;
        exp_mp = exp_mp + 1;
        checks++;
        if (bus.branch_mispredict_o !== 1'b1 || bus.mispredict_target_o !== 32'h5C0) begin
            failures++;
            $display("FAIL b2b redirect: got pulse=%b target=%h expected pulse=1 target=5c0",
                     bus.branch_mispredict_o, bus.mispredict_target_o);
        end
        check_counts("b2b");
        retire();
    endtask

    task automatic test_flush();
        drive_branch(32'h700, 26'h20, 1'b1, 1'b1);
        tick();
        clear_decode();
        bus.flag_valid_i     = 1'b1;
        bus.flag_i           = 1'b0;
        bus.pipeline_flush_i = 1'b1;
        tick();
        bus.flag_valid_i     = 1'b0;
        bus.pipeline_flush_i = 1'b0;
        checks++;
        if (bus.branch_mispredict_o !== 1'b0 || bus.execute_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_resolve: got pulse=%b stall=%b expected 0/0",
                     bus.branch_mispredict_o, bus.execute_stall_o);
        end
        check_counts("flush_resolve");
        // Only an EMPTY resolver accepts a branch without an execute advance.
        drive_branch(32'h800, 26'h4, 1'b1, 1'b0);
        tick();
        clear_decode();
        checks++;
        if (bus.execute_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: got stall=%b expected 1", bus.execute_stall_o);
        end
        bus.pipeline_flush_i = 1'b1;
        tick();
        bus.pipeline_flush_i = 1'b0;
        // Capture and flush together: nothing is captured.
        drive_branch(32'h900, 26'h4, 1'b1, 1'b0);
        bus.pipeline_flush_i = 1'b1;
        tick();
        clear_decode();
        bus.pipeline_flush_i = 1'b0;
        checks++;
        if (bus.execute_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_capture: got stall=%b expected 0", bus.execute_stall_o);
        end
        bus.flag_valid_i = 1'b1;
        tick();
        bus.flag_valid_i = 1'b0;
        check_counts("flush_capture");
    endtask

    task automatic test_saturation();
        force dut.g_perf.u_branch_cnt.count_q = 32'hFFFF_FFFE;
        force dut.g_perf.u_mispredict_cnt.count_q = 32'hFFFF_FFFE;
        tick();
        release dut.g_perf.u_branch_cnt.count_q;
        release dut.g_perf.u_mispredict_cnt.count_q;
        exp_br = 32'hFFFF_FFFE;
        exp_mp = 32'hFFFF_FFFE;
        check_counts("sat_preload");
        for (int i = 0; i < 3; i++) begin
            drive_branch(32'h300, 26'h40, 1'b1, 1'b1);
            tick();
            clear_decode();
            bus.flag_valid_i = 1'b1;
            bus.flag_i       = 1'b0;
            tick();
            bus.flag_valid_i = 1'b0;
            retire();
        end
        exp_br = 32'hFFFF_FFFF;
        exp_mp = 32'hFFFF_FFFF;
        check_counts("saturate");
    endtask

    task automatic test_reset_mid();
        drive_branch(32'hA00, 26'h4, 1'b1, 1'b0);
        tick();
        clear_decode();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_br = 32'd0;
        exp_mp = 32'd0;
        checks++;
        if (bus.execute_stall_o !== 1'b0 || bus.mispredict_target_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got stall=%b target=%h expected 0/0",
                     bus.execute_stall_o, bus.mispredict_target_o);
        end
        check_counts("reset_mid");
    endtask

    initial begin
        test_reset();
        test_predicted_correct();
        test_mispredict_bnf();
        test_wrong_taken();
        test_non_branch();
        test_delayed_flag();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_or1k_branch_resolver.md
# pu_or1k_branch_resolver

Execute-stage companion to the static branch predictor: captures each conditional branch (l.bf/l.bnf) with its predicted direction as it leaves decode, resolves it against the real SR[F] once the flag is valid in execute, and issues a one-cycle misprediction redirect to fetch. Also keeps saturating branch and mispredict statistics for the performance-counter SPRs.

## Interface
- OPTION_OPERAND_WIDTH, 32: PC/target width.
- FEATURE_PERF_COUNTERS, "ENABLED": "NONE" ties both count outputs to 0 and removes the counter logic.
- clk  in  1  core clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- padv_decode_i  in  1  decode→execute advance; captures the decode-stage branch.
- pc_decode_i  in  OPTION_OPERAND_WIDTH  PC of the decode-stage instruction.
- op_bf_i, op_bnf_i  in  1 each  decode-stage instruction is l.bf / l.bnf (never both).
- immjbr_i  in  26  branch offset, in words.
- predicted_flag_i  in  1  predictor output for the decode-stage instruction.
- flag_valid_i  in  1  SR[F] is final for the instruction in execute.
- flag_i  in  1  SR[F].
- padv_execute_i  in  1  execute→ctrl advance; retires the held branch.
- pipeline_flush_i  in  1  discard all in-flight state.
- branch_mispredict_o  out  1  one-cycle redirect pulse.
- mispredict_target_o  out  OPTION_OPERAND_WIDTH  correct fetch PC; valid with the pulse.
- execute_stall_o  out  1  branch held in execute, not yet resolved.
- branch_count_o  out  32  resolved conditional branches, saturating.
- mispredict_count_o  out  32  mispredictions, saturating.

## Operation
- FSM states: EMPTY, WAIT_FLAG, RESOLVED.
- EMPTY: on padv_decode_i & (op_bf_i|op_bnf_i), capture pc, is_bf, predicted_flag, target = pc_decode_i + {sext(immjbr_i),2'b00} mod 2^W, and fall = pc_decode_i + 8 (the delay slot is always executed). Go to WAIT_FLAG.
- WAIT_FLAG: when flag_valid_i, taken = is_bf ? flag_i : !flag_i; mispredict = taken != predicted; go to RESOLVED. The counters update in the same cycle: branch +1, mispredict +1 if mispredicted.
- RESOLVED: on padv_execute_i, a new branch captured in the same cycle goes to WAIT_FLAG; otherwise go to EMPTY.
- padv_execute_i while in WAIT_FLAG is a protocol error: execute_stall_o must already be holding the pipeline. The bench asserts it never happens.
- Redirect: the next cycle after resolution with mispredict, branch_mispredict_o=1 for exactly one cycle. mispredict_target_o = taken ? target : fall.
- Non-branch instructions passing through decode are ignored and do not change state.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Reset: state EMPTY; branch_mispredict_o=0, mispredict_target_o=0, execute_stall_o=0, both counters 0.
- Capture → earliest resolution: 1 cycle if flag_valid_i is already high in the first WAIT_FLAG cycle.
- Resolution → redirect pulse: 1 cycle, registered.
- execute_stall_o is combinational: 1 only in WAIT_FLAG.
- pipeline_flush_i in any state: next state EMPTY. It also kills a redirect pulse due in the next cycle, so the output is 0 there. Counters already updated are kept.
- flush and padv_decode_i in the same cycle: flush wins and nothing is captured.
- Flag resolution and flush in the same cycle: no count and no pulse.
- rst mid-operation behaves like flush, and additionally clears the counters.

## Structure
- Shared package pu_or1k_branch_pkg holds:
  - the state enum, branch_state_t;
  - the delay-slot fall-through offset constant, 8;
  - the counter width constant, 32.
- One sub-module, pu_or1k_sat_counter: parameterized width, with sync reset, inc and saturation. It is instantiated twice.

## Test plan
- Predicted-correct backward l.bf: pc=0x100, imm=0x3FFFFFC, predicted=1; flag_valid=1, flag=1 one cycle later. Required: no pulse, branch_count=1, mispredict_count=0.
- Mispredicted forward l.bnf: pc=0x200, imm=0x10, predicted=0; flag=0. Required: pulse one cycle after resolve, target=0x240, mispredict_count=1.
- Wrongly predicted taken: l.bf at pc=0x300, predicted=1, flag=0. Required: target=0x308.
- Delayed flag: flag_valid held low 5 cycles. Required: execute_stall_o high for exactly those 5 cycles, then resolves the next cycle.
- Flush in the resolve cycle of a mispredict. Required: no pulse, counters unchanged, state EMPTY. Capture plus flush in the same cycle: nothing captured.
- Saturation: force the counters to 0xFFFF_FFFE and resolve 3 mispredicts. Required: both counters read 0xFFFF_FFFF. rst then clears both to 0.
